// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution kernel scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    FRAME_END = 2'd2
  } conv_sched_state_e;

  // Number of kernel groups each window is replayed over.
  function automatic int cycles_per_pixel(input int k, input int pe);
    return k / pe;
  endfunction

endpackage

// File: rtl/conv_window_fifo.sv
// Window FIFO: circular buffer of Depth entries with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module conv_window_fifo #(
  parameter int Width = 72,
  parameter int Depth = 4,
  localparam int CW = $clog2(Depth + 1),
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset also discards buffered windows.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Kernel-group scheduler: buffers NxN windows, replays each one once per
// kernel group to the shared PEs, tracks pixel position and frame end.
// Optional macro CONV_SCHED_PERF_EN adds a saturating stall counter port.
module conv_kernel_scheduler
  import conv_pkg::*;
#(
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 4,
  parameter int N                  = 3,
  parameter int BitSize            = 8,
  parameter int ImageWidth         = 16,
  parameter int FifoDepth          = 4,
  localparam int CyclesPerPixel    = cycles_per_pixel(NumberOfK, ProcessingElements),
  localparam int GW                = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1,
  localparam int FramePixels       = ImageWidth * ImageWidth,
  localparam int PW                = $clog2(FramePixels),
  localparam int DW                = N * N * BitSize
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          pe_valid,
  output logic [DW-1:0] pe_data,
  output logic [GW-1:0] pe_kgroup,
  input  logic          pe_ready,
  output logic [PW-1:0] pixel_idx,
  output logic          frame_done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int CW = $clog2(FifoDepth + 1);
  localparam logic [GW-1:0] LastGroup = GW'(CyclesPerPixel - 1);
  localparam logic [PW-1:0] LastPixel = PW'(FramePixels - 1);

  if (NumberOfK % ProcessingElements != 0) begin : g_chk_k
    $error("NumberOfK must be a multiple of ProcessingElements");
  end
  if (FifoDepth < 2) begin : g_chk_depth
    $error("FifoDepth must be at least 2");
  end

  conv_sched_state_e state, state_nxt;
  logic              push, pop, accept, last_group;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_nxt;

  conv_window_fifo #(
    .Width (DW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (pe_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign pe_valid   = (state == ISSUE);
  assign frame_done = (state == FRAME_END);
  assign accept     = pe_valid && pe_ready;
  assign last_group = (pe_kgroup == LastGroup);
  assign pop        = accept && last_group;
  // Occupancy after this edge, so a same-cycle push keeps ISSUE going without a bubble.
  assign count_nxt  = fifo_count + CW'(push) - CW'(pop);

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (pop) begin
          if (pixel_idx == LastPixel) state_nxt = FRAME_END;
          else if (count_nxt == '0)   state_nxt = IDLE;
        end
      end
      FRAME_END: begin
        state_nxt = fifo_empty ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Kernel-group and pixel position counters, advanced on PE acceptance.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pe_kgroup <= '0;
      pixel_idx <= '0;
    end else if (accept) begin
      if (last_group) begin
        pe_kgroup <= '0;
        pixel_idx <= (pixel_idx == LastPixel) ? '0 : pixel_idx + PW'(1);
      end else begin
        pe_kgroup <= pe_kgroup + GW'(1);
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Saturating count of cycles where the PEs back-pressure a presented group.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) stall_cnt <= '0;
    else if (pe_valid && !pe_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
